puf_host_requester: RTL and testbench
=====================================

// Module: puf_host_requester
// PURPOSE
//  Initiator end of the PUF UART protocol: issues request byte + challenge byte, then receives the
//  response stream (header + NUM_RESPONSES words, MSB-first bytes) and re-packs it into words.
//  Sits between a byte-level uart instance and a word consumer (BRAM, checker, or compare logic).
//  Used for on-board loopback/self-test and for chaining a second board as PUF host.
// PARAMETERS
//  DATA_BITS      8           UART byte width
//  RESPONSE_BITS  32          response word width; multiple of DATA_BITS
//  NUM_RESPONSES  1280        response words expected per challenge
//  CHALLENGE_BITS 8           challenge width (== DATA_BITS, one challenge byte)
//  TIMEOUT_BITS   24          idle-gap counter width; expiry at all-ones
//  REQUEST_ID     8'hAA       command byte sent before the challenge
//  RESPONSE_ID    8'hAB       header byte expected before response data
// PORTS
//  clk          in   1                 system clock (100 MHz domain)
//  reset        in   1                 asynchronous reset, active-low
//  start        in   1                 1-cycle pulse; sampled only in IDLE
//  challenge    in   CHALLENGE_BITS    captured on accepted start
//  tx_data      out  DATA_BITS         byte to uart transmitter
//  tx_enable    out  1                 1-cycle send pulse
//  tx_busy      in   1                 uart transmitter busy
//  rx_data      in   DATA_BITS         byte from uart receiver
//  rx_valid     in   1                 rx_data valid, 1 cycle
//  rx_enable    out  1                 enables uart receiver
//  resp_word    out  RESPONSE_BITS     packed response word
//  resp_valid   out  1                 1-cycle strobe, resp_word/resp_index valid
//  resp_index   out  $clog2(NUM_RESPONSES) word index, 0-based
//  busy         out  1                 high outside IDLE
//  done         out  1                 1-cycle pulse: all words received
//  error        out  1                 sticky until next accepted start
//  err_code     out  2                 0 none, 1 bad header, 2 timeout
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0. Reset mid-transfer aborts silently (no done/error).
//  - FSM: IDLE -> SEND_REQ -> WAIT_REQ -> SEND_CHAL -> WAIT_CHAL -> WAIT_HDR -> RECV -> IDLE.
//  - IDLE: start=1 captures challenge, clears error/err_code, -> SEND_REQ. start elsewhere ignored.
//  - SEND_x: when tx_busy=0, tx_data=byte, tx_enable=1 one cycle, -> WAIT_x. tx_data held until
//    WAIT_x exits. WAIT_x: wait tx_busy=1 then tx_busy=0 (two-phase), then next state.
//  - rx_enable=1 from entry to WAIT_CHAL until leaving RECV (receiver armed before challenge sent).
//  - WAIT_HDR: rx_valid with rx_data==RESPONSE_ID -> RECV; any other byte -> IDLE, error=1, code=1.
//  - RECV: bytes shifted in MSB-first; after RESPONSE_BITS/DATA_BITS bytes, resp_valid=1 for one
//    cycle the following clock, resp_index=word count; byte counter wraps to 0 same cycle.
//  - After word NUM_RESPONSES-1: resp_valid and done assert same cycle, -> IDLE.
//  - Timeout: counter clears on every rx_valid and on entering WAIT_HDR; increments in WAIT_HDR/RECV;
//    at all-ones -> IDLE, error=1, code=2, partial word discarded. Also applied in WAIT_x states
//    (tx_busy stuck) with code=2.
//  - rx_valid in a cycle where byte count completes and timeout expires: byte wins, counter clears.
//  - Latency: last data byte rx_valid -> resp_valid next cycle. No backpressure on resp_*.
// STRUCTURE
//  - Package puf_host_pkg: state_t enum, err_code_t enum, REQUEST_ID/RESPONSE_ID defaults,
//    BYTES_PER_WORD localparam function.
//  - Sub-module resp_word_packer: byte shift register + byte counter + word index, clear/shift_en
//    inputs, word_valid output. FSM, tx sequencing and timeout stay in top.
// TESTING
//  1 start, challenge=8'h3C, uart model -> tx bytes AA,3C in order; tx_enable exactly 2 pulses.
//  2 reply AB + 1280x4 bytes (word k = 32'hC0DE0000+k) -> 1280 resp_valid, index 0..1279, words
//    match, done on last, error=0.
//  3 reply 8'h55 as header -> error=1, err_code=1, no resp_valid, busy=0 next cycle.
//  4 stop after 2 bytes of word 7 -> timeout: error=1, code=2, resp_index max 6, no done.
//  5 assert reset during word 500 -> all outputs 0 same cycle; new start runs scenario 2 cleanly.
//  6 start pulses while busy and during tx -> ignored; challenge change after capture has no effect.

Source files
------------

// File: rtl/puf_host_requester_pkg.sv
// Shared types and helpers for the PUF host requester.
// This covers the FSM state encoding, error codes, default protocol IDs and width helpers.
package puf_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_REQ,
      ST_WAIT_REQ,
      ST_SEND_CHAL,
      ST_WAIT_CHAL,
      ST_WAIT_HDR,
      ST_RECV
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_HEADER  = 2'd1,
      ERR_TIMEOUT = 2'd2
   } err_code_t;

   localparam logic [7:0] DEF_REQUEST_ID  = 8'hAA;
   localparam logic [7:0] DEF_RESPONSE_ID = 8'hAB;

   // Number of UART bytes that make up one response word.
   function automatic int bytes_per_word(input int resp_bits, input int data_bits);
      return resp_bits / data_bits;
   endfunction

   // Counter width able to hold 0..n-1. A width of at least 1 is kept so that
   // single-value counters stay legal vectors.
   function automatic int ctr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/puf_host_requester_resp_word_packer.sv
// Response word packer.
// Shifts received bytes in MSB-first and flags each completed word one clock
// after its last byte arrives. It also tracks the index of the word.
module resp_word_packer
   import puf_host_pkg::*;
#(
   parameter int DATA_BITS     = 8,
   parameter int RESPONSE_BITS = 32,
   parameter int NUM_WORDS     = 1280
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         shift_en,
   input  logic [DATA_BITS-1:0]         data_in,
   output logic [RESPONSE_BITS-1:0]     word,
   output logic                         word_valid,
   output logic [$clog2(NUM_WORDS)-1:0] word_index,
   output logic [$clog2(NUM_WORDS)-1:0] word_count,
   output logic                         last_byte
);

   localparam int BPW   = bytes_per_word(RESPONSE_BITS, DATA_BITS);
   localparam int CNT_W = ctr_width(BPW);

   logic [CNT_W-1:0] byte_cnt;

   // The byte arriving now completes a word.
   assign last_byte = (byte_cnt == CNT_W'(BPW - 1));

   // Shift register, byte counter and word index/count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the shift register is reset too, because it drives resp_word and that output must read 0 while in reset.
         word       <= '0;
         word_valid <= 1'b0;
         word_index <= '0;
         word_count <= '0;
         byte_cnt   <= '0;
      end else if (clear) begin
         word       <= '0;
         word_valid <= 1'b0;
         word_index <= '0;
         word_count <= '0;
         byte_cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register here update from pre-edge values, so ordering does not matter.
         word_valid <= shift_en && last_byte;
         if (shift_en) begin
            word <= (word << DATA_BITS) | RESPONSE_BITS'(data_in);
            if (last_byte) begin
               byte_cnt   <= '0;
               word_index <= word_count;
               word_count <= word_count + 1'b1;
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/puf_host_requester.sv
// PUF host requester.
// Sends the request ID and the challenge byte over a byte UART, then receives the
// header and NUM_RESPONSES words and hands each packed word to the consumer.
module puf_host_requester
   import puf_host_pkg::*;
#(
   parameter int                    DATA_BITS      = 8,
   parameter int                    RESPONSE_BITS  = 32,
   parameter int                    NUM_RESPONSES  = 1280,
   parameter int                    CHALLENGE_BITS = 8,
   parameter int                    TIMEOUT_BITS   = 24,
   parameter logic [DATA_BITS-1:0]  REQUEST_ID     = DEF_REQUEST_ID,
   parameter logic [DATA_BITS-1:0]  RESPONSE_ID    = DEF_RESPONSE_ID
)(
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [CHALLENGE_BITS-1:0]        challenge,
   output logic [DATA_BITS-1:0]             tx_data,
   output logic                             tx_enable,
   input  logic                             tx_busy,
   input  logic [DATA_BITS-1:0]             rx_data,
   input  logic                             rx_valid,
   output logic                             rx_enable,
   output logic [RESPONSE_BITS-1:0]         resp_word,
   output logic                             resp_valid,
   output logic [$clog2(NUM_RESPONSES)-1:0] resp_index,
   output logic                             busy,
   output logic                             done,
   output logic                             error,
   output logic [1:0]                       err_code
);

   localparam int IDX_W = $clog2(NUM_RESPONSES);

   state_t                    state_q, state_d;
   logic [DATA_BITS-1:0]      tx_data_q, tx_data_d;
   logic                      tx_enable_q, tx_enable_d;
   logic                      seen_busy_q, seen_busy_d;
   logic [CHALLENGE_BITS-1:0] chal_q, chal_d;
   logic                      error_q, error_d;
   err_code_t                 code_q, code_d;
   logic                      done_q, done_d;
   logic [TIMEOUT_BITS-1:0]   timer_q, timer_d;

   logic                      pack_clear;
   logic                      pack_shift;
   logic                      last_byte;
   logic [IDX_W-1:0]          word_count;
   logic                      tx_phase;
   logic                      rx_phase;
   logic                      expired;

   resp_word_packer #(
      .DATA_BITS     (DATA_BITS),
      .RESPONSE_BITS (RESPONSE_BITS),
      .NUM_WORDS     (NUM_RESPONSES)
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (pack_clear),
      .shift_en   (pack_shift),
      .data_in    (rx_data),
      .word       (resp_word),
      .word_valid (resp_valid),
      .word_index (resp_index),
      .word_count (word_count),
      .last_byte  (last_byte)
   );

   // The idle-gap watchdog also covers the transmit states, so a stuck
   // transmitter cannot hang the requester.
   assign tx_phase = (state_q == ST_SEND_REQ)  || (state_q == ST_WAIT_REQ) ||
                     (state_q == ST_SEND_CHAL) || (state_q == ST_WAIT_CHAL);
   assign rx_phase = (state_q == ST_WAIT_HDR)  || (state_q == ST_RECV);
   // A byte arriving in the expiry cycle wins over the timeout.
   assign expired  = (tx_phase || rx_phase) && (timer_q == '1) && !rx_valid;

   // State register and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         tx_data_q   <= '0;
         tx_enable_q <= 1'b0;
         seen_busy_q <= 1'b0;
         chal_q      <= '0;
         error_q     <= 1'b0;
         code_q      <= ERR_NONE;
         done_q      <= 1'b0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         tx_enable_q <= tx_enable_d;
         seen_busy_q <= seen_busy_d;
         chal_q      <= chal_d;
         error_q     <= error_d;
         code_q      <= code_d;
         done_q      <= done_d;
         timer_q     <= timer_d;
      end
   end

   // Next-state logic, tx sequencing, header check and timeout handling.
   always_comb begin
      // NOTE: every signal gets a default first so that no path through the case infers a latch.
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      tx_enable_d = 1'b0;
      seen_busy_d = seen_busy_q;
      chal_d      = chal_q;
      error_d     = error_q;
      code_d      = code_q;
      done_d      = 1'b0;
      pack_clear  = 1'b0;
      pack_shift  = 1'b0;
      timer_d     = (tx_phase || rx_phase) ? timer_q + 1'b1 : '0;
      if (rx_valid) begin
         timer_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               chal_d  = challenge;
               error_d = 1'b0;
               code_d  = ERR_NONE;
               timer_d = '0;
               state_d = ST_SEND_REQ;
            end
         end
         ST_SEND_REQ: begin
            if (!tx_busy) begin
               tx_data_d   = REQUEST_ID;
               tx_enable_d = 1'b1;
               seen_busy_d = 1'b0;
               timer_d     = '0;
               state_d     = ST_WAIT_REQ;
            end
         end
         ST_WAIT_REQ: begin
            if (tx_busy) begin
               seen_busy_d = 1'b1;
            end else if (seen_busy_q) begin
               timer_d = '0;
               state_d = ST_SEND_CHAL;
            end
         end
         ST_SEND_CHAL: begin
            if (!tx_busy) begin
               tx_data_d   = DATA_BITS'(chal_q);
               tx_enable_d = 1'b1;
               seen_busy_d = 1'b0;
               timer_d     = '0;
               state_d     = ST_WAIT_CHAL;
            end
         end
         ST_WAIT_CHAL: begin
            if (tx_busy) begin
               seen_busy_d = 1'b1;
            end else if (seen_busy_q) begin
               timer_d = '0;
               state_d = ST_WAIT_HDR;
            end
         end
         ST_WAIT_HDR: begin
            if (rx_valid) begin
               if (rx_data == RESPONSE_ID) begin
                  pack_clear = 1'b1;
                  state_d    = ST_RECV;
               end else begin
                  error_d = 1'b1;
                  code_d  = ERR_HEADER;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_RECV: begin
            if (rx_valid) begin
               pack_shift = 1'b1;
               if (last_byte && (word_count == IDX_W'(NUM_RESPONSES - 1))) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A watchdog expiry aborts any active phase and discards the partial word.
      if (expired) begin
         tx_enable_d = 1'b0;
         error_d     = 1'b1;
         code_d      = ERR_TIMEOUT;
         state_d     = ST_IDLE;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_enable = tx_enable_q;
   assign rx_enable = (state_q == ST_WAIT_CHAL) || (state_q == ST_WAIT_HDR) || (state_q == ST_RECV);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign error     = error_q;
   assign err_code  = code_q;

endmodule

// File: tb/tb_puf_host_requester.sv
// Scoreboard testbench for puf_host_requester.
// Stimulus tasks push the expected tx bytes and response words into queues.
// Monitors on the falling edge pop those entries and compare them with what the DUT presents.
module tb_puf_host_requester;

   localparam int NUM   = 1280;
   localparam int TO_W  = 10;
   localparam int IDX_W = $clog2(NUM);

   typedef struct {
      logic [31:0] word;
      int          idx;
      bit          last;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [7:0]       challenge = '0;
   logic [7:0]       tx_data;
   logic             tx_enable;
   logic             tx_busy = 1'b0;
   logic [7:0]       rx_data = '0;
   logic             rx_valid = 1'b0;
   logic             rx_enable;
   logic [31:0]      resp_word;
   logic             resp_valid;
   logic [IDX_W-1:0] resp_index;
   logic             busy;
   logic             done;
   logic             error;
   logic [1:0]       err_code;

   int         checks = 0;
   int         failures = 0;
   int         tx_pulses = 0;
   int         done_cnt = 0;
   int         last_index = -1;
   exp_t       sb_q[$];
   logic [7:0] tx_q[$];

   puf_host_requester #(
      .NUM_RESPONSES (NUM),
      .TIMEOUT_BITS  (TO_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .challenge  (challenge),
      .tx_data    (tx_data),
      .tx_enable  (tx_enable),
      .tx_busy    (tx_busy),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_enable  (rx_enable),
      .resp_word  (resp_word),
      .resp_valid (resp_valid),
      .resp_index (resp_index),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // UART transmitter model: busy for three cycles after each send pulse.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tx_enable) begin
            tx_busy = 1'b1;
            repeat (3) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // Transmit monitor.
   always @(negedge clk) begin
      if (tx_enable) begin
         tx_pulses++;
         if (tx_q.size() == 0) begin
            check("tx_unexpected", {56'd0, tx_data}, 64'hFFFF);
         end else begin
            check("tx_byte", {56'd0, tx_data}, {56'd0, tx_q.pop_front()});
         end
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      if (resp_valid) begin
         last_index = int'(resp_index);
         if (sb_q.size() == 0) begin
            check("resp_unexpected", {21'd0, resp_index, resp_word}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("resp_word", {32'd0, resp_word}, {32'd0, e.word});
            check("resp_index", {53'd0, resp_index}, 64'(e.idx));
            check("resp_done", {63'd0, done}, {63'd0, e.last});
         end
      end
      if (done) begin
         done_cnt++;
         if (!resp_valid) check("done_without_valid", 64'd1, 64'd0);
      end
   end

   function automatic logic [63:0] all_outs();
      return {5'd0, tx_data, tx_enable, rx_enable, resp_word, resp_valid, resp_index,
              busy, done, error, err_code};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_data = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_word(input int k, input bit last);
      logic [31:0] w;
      w = 32'hC0DE0000 + 32'(k);
      sb_q.push_back('{w, k, last});
      for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
   endtask

   task automatic pulse_start(input logic [7:0] c);
      @(posedge clk);
      #1 challenge = c;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic do_start(input logic [7:0] c);
      tx_q.push_back(8'hAA);
      tx_q.push_back(c);
      pulse_start(c);
   endtask

   task automatic wait_tx_done(input int base);
      int n = 0;
      while ((tx_pulses < base + 2 || tx_busy) && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      check("tx_sequence_bound", {63'd0, n >= 200}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(posedge clk);
         #1 n++;
      end
      check("idle_bound", {63'd0, busy}, 64'd0);
   endtask

   task automatic run_full(input logic [7:0] c);
      int base;
      int d0;
      base = tx_pulses;
      d0   = done_cnt;
      do_start(c);
      wait_tx_done(base);
      send_byte(8'hAB);
      for (int k = 0; k < NUM; k++) send_word(k, k == NUM - 1);
      repeat (2) @(posedge clk);
      #1;
      check("full_done_count", 64'(done_cnt - d0), 64'd1);
      check("full_tx_pulses", 64'(tx_pulses - base), 64'd2);
      check("full_error", {62'd0, error, 1'b0} | {62'd0, err_code}, 64'd0);
      check("full_busy", {63'd0, busy}, 64'd0);
      check("full_sb_empty", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int base;
      int d0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1 check("reset_outputs", all_outs(), 64'd0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Request/challenge bytes and a full response stream.
      run_full(8'h3C);

      // Bad header.
      base = tx_pulses;
      do_start(8'h3C);
      wait_tx_done(base);
      send_byte(8'h55);
      check("hdr_busy", {63'd0, busy}, 64'd0);
      check("hdr_error", {63'd0, error}, 64'd1);
      check("hdr_code", {62'd0, err_code}, 64'd1);
      check("hdr_tx_pulses", 64'(tx_pulses - base), 64'd2);

      // Timeout two bytes into word 7.
      base = tx_pulses;
      d0   = done_cnt;
      do_start(8'h11);
      wait_tx_done(base);
      send_byte(8'hAB);
      for (int k = 0; k < 7; k++) send_word(k, 1'b0);
      send_byte(8'hC0);
      send_byte(8'hDE);
      wait_idle(2000);
      check("to_error", {63'd0, error}, 64'd1);
      check("to_code", {62'd0, err_code}, 64'd2);
      check("to_last_index", 64'(last_index), 64'd6);
      check("to_no_done", 64'(done_cnt - d0), 64'd0);
      check("to_sb_empty", 64'(sb_q.size()), 64'd0);

      // Reset in the middle of word 500, then a clean full run.
      base = tx_pulses;
      do_start(8'h77);
      wait_tx_done(base);
      send_byte(8'hAB);
      for (int k = 0; k < 500; k++) send_word(k, 1'b0);
      send_byte(8'hC0);
      send_byte(8'hDE);
      @(posedge clk);
      #3 reset = 1'b0;
      #1 check("midreset_outputs", all_outs(), 64'd0);
      check("midreset_sb_empty", 64'(sb_q.size()), 64'd0);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      run_full(8'h3C);

      // Start pulses while busy and a challenge change after capture are ignored.
      base = tx_pulses;
      do_start(8'h5A);
      challenge = 8'hFF;
      pulse_start(8'hFF);
      pulse_start(8'h00);
      wait_tx_done(base);
      send_byte(8'hAB);
      for (int k = 0; k < 3; k++) send_word(k, 1'b0);
      pulse_start(8'h12);
      wait_idle(2000);
      check("ign_code", {62'd0, err_code}, 64'd2);
      check("ign_last_index", 64'(last_index), 64'd2);
      check("ign_tx_pulses", 64'(tx_pulses - base), 64'd2);

      repeat (5) @(posedge clk);
      #1;
      check("final_sb_empty", 64'(sb_q.size()), 64'd0);
      check("final_tx_q_empty", 64'(tx_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
